// File: rtl/logical_result_sequencer.sv
// Operand latch and result display sequencer around the 4-bit Logical unit.
// Captures X/Y, snapshots the unit's results and steps an 8-bit display through them.
module logical_result_sequencer #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Load,
    input  logic [3:0] XIn,
    input  logic [3:0] YIn,
    input  logic       Step,
    input  logic       AutoEn,
    input  logic [3:0] AOut,
    input  logic [3:0] OOut,
    input  logic [3:0] EXOut,
    input  logic [7:0] NOut,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic [2:0] Sel,
    output logic [7:0] Disp,
    output logic       Valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHOW    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t           state;
    logic [3:0]       sa, so, se;
    logic [7:0]       sn;
    logic             stepq;
    logic [CNT_W-1:0] cnt;
    logic             step_edge;
    logic             advance;

    assign step_edge = Step & ~stepq;
    // A Step edge coinciding with dwell expiry still yields a single advance.
    assign advance   = step_edge | (AutoEn & (cnt == DWELL_LAST));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            X     <= 4'h0;
            Y     <= 4'h0;
            Sel   <= 3'd0;
            Valid <= 1'b0;
            sa    <= 4'h0;
            so    <= 4'h0;
            se    <= 4'h0;
            sn    <= 8'h00;
            stepq <= 1'b0;
            cnt   <= '0;
        end else begin
            stepq <= Step;
            if (Load) begin
                X     <= XIn;
                Y     <= YIn;
                Valid <= 1'b0;
                cnt   <= '0;
                state <= CAPTURE;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                    end
                    CAPTURE: begin
                        sa    <= AOut;
                        so    <= OOut;
                        se    <= EXOut;
                        sn    <= NOut;
                        Sel   <= 3'd0;
                        Valid <= 1'b1;
                        cnt   <= '0;
                        state <= SHOW;
                    end
                    SHOW: begin
                        if (advance) begin
                            Sel <= (Sel == 3'd4) ? 3'd0 : Sel + 3'd1;
                            cnt <= '0;
                        end else if (AutoEn) begin
                            cnt <= cnt + 1'b1;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Display is selected purely from registered state; inputs never reach Disp directly.
    always_comb begin
        Disp = 8'h00;
        if (state == SHOW) begin
            case (Sel)
                3'd0:    Disp = {4'h0, sa};
                3'd1:    Disp = {4'h0, so};
                3'd2:    Disp = {4'h0, se};
                3'd3:    Disp = sn;
                3'd4:    Disp = {X, Y};
                default: Disp = 8'h00;
            endcase
        end
    end

endmodule
